// File: rtl/rf_multiport.sv
// Two-write / two-read register file with an advisory busy scoreboard.
// Latency: reads and busy lookups are combinational; writes and scoreboard updates land on the next rising edge.
// Backpressure: none; every read, write and issue proceeds every cycle whatever the busy state.
module rf_multiport #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite0,
  input  logic [ADDR_W-1:0] RDaddr0,
  input  logic [WIDTH-1:0]  RDdata0,
  input  logic              RegWrite1,
  input  logic [ADDR_W-1:0] RDaddr1,
  input  logic [WIDTH-1:0]  RDdata1,
  input  logic [ADDR_W-1:0] RSaddr,
  input  logic [ADDR_W-1:0] RTaddr,
  output logic [WIDTH-1:0]  RSdata,
  output logic [WIDTH-1:0]  RTdata,
  input  logic              Issue,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              RSbusy,
  output logic              RTbusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Effective enables: anything aimed at the hardwired zero register is dropped here,
  // so neither the array, the scoreboard nor the forwarding paths ever see it.
  logic wen0;
  logic wen1;
  logic issue_en;
  logic same_dst;

  // Forwarding hits per read port and write port.
  logic rs_hit0;
  logic rs_hit1;
  logic rt_hit0;
  logic rt_hit1;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualify write/issue enables against the zero register and detect same-target writes.
  always_comb begin
    wen0     = RegWrite0 && !is_zero(RDaddr0);
    wen1     = RegWrite1 && !is_zero(RDaddr1);
    issue_en = Issue && !is_zero(IssueAddr);
    same_dst = wen1 && (RDaddr1 == RDaddr0);
  end

  // Register array: reset clears everything; on a same-address collision port 1 wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wen0 && !same_dst) begin
        regs[RDaddr0] <= RDdata0;
      end
      if (wen1) begin
        regs[RDaddr1] <= RDdata1;
      end
    end
  end

  // Scoreboard next state: writes retire producers, then a same-cycle issue re-marks
  // its target since it stands for a newer producer than the one being written back.
  always_comb begin
    busy_next = busy;
    if (wen0) begin
      busy_next[RDaddr0] = 1'b0;
    end
    if (wen1) begin
      busy_next[RDaddr1] = 1'b0;
    end
    if (issue_en) begin
      busy_next[IssueAddr] = 1'b1;
    end
  end

  // Scoreboard register; reset drops all pending producers, including a same-cycle issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Match read addresses against the enabled write ports for forwarding.
  always_comb begin
    rs_hit0 = wen0 && (RDaddr0 == RSaddr);
    rs_hit1 = wen1 && (RDaddr1 == RSaddr);
    rt_hit0 = wen0 && (RDaddr0 == RTaddr);
    rt_hit1 = wen1 && (RDaddr1 == RTaddr);
  end

  // Read port A: stored value, zero register override, then newest in-flight write data.
  // A forwarded value is by definition ready, so its busy flag is masked.
  always_comb begin
    RSdata = regs[RSaddr];
    RSbusy = busy[RSaddr];
    if (is_zero(RSaddr)) begin
      RSdata = '0;
      RSbusy = 1'b0;
    end else if (BYPASS != 0) begin
      if (rs_hit1) begin
        RSdata = RDdata1;
      end else if (rs_hit0) begin
        RSdata = RDdata0;
      end
      if (rs_hit0 || rs_hit1) begin
        RSbusy = 1'b0;
      end
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    RTdata = regs[RTaddr];
    RTbusy = busy[RTaddr];
    if (is_zero(RTaddr)) begin
      RTdata = '0;
      RTbusy = 1'b0;
    end else if (BYPASS != 0) begin
      if (rt_hit1) begin
        RTdata = RDdata1;
      end else if (rt_hit0) begin
        RTdata = RDdata0;
      end
      if (rt_hit0 || rt_hit1) begin
        RTbusy = 1'b0;
      end
    end
  end

endmodule
